drp_responder: RTL

- Synthesizable DRP responder that emulates the XADC dynamic reconfiguration port (DRP) for fabric-only simulation and bring-up of DRP initiators.
- Holds a 32-entry status bank written by a fabric measurement port and a 16-entry config bank written over DRP.
- Answers den/dwe transactions with drdy after a fixed latency and generates a periodic eoc pulse.
- Drop-in for the XADC wizard on the initiator side; the wiring is identical.

---
 rtl/drp_responder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/drp_responder.sv
// DRP responder emulating the XADC DRP: 32-entry status bank, 16-entry config bank, periodic eoc.
// Optional sticky protocol-error flag is built only when DRP_PROTO_ERR_EN is defined.
module drp_responder #(
    parameter int RD_LATENCY = 4,
    parameter int EOC_PERIOD = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        den,
    input  logic        dwe,
    input  logic [6:0]  daddr,
    input  logic [15:0] di,
    output logic [15:0] dout,
    output logic        drdy,
    output logic        eoc,
    input  logic        meas_we,
    input  logic [4:0]  meas_addr,
    input  logic [15:0] meas_data,
    output logic        proto_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0]  LAT_M1   = 4'(RD_LATENCY - 1);
    localparam logic [15:0] EOC_LAST = 16'(EOC_PERIOD - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_count;
    logic [3:0]  w_next_count;
    logic        r_we;
    logic [6:0]  r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_snap;
    logic [15:0] w_snap_next;
    logic [15:0] w_rd_data;
    logic [15:0] r_dout;
    logic        r_drdy;
    logic [15:0] r_eoc_cnt;
    logic [15:0] w_eoc_next;
    logic        r_eoc;
    logic        w_accept;
    logic        w_in_bank;
    logic [15:0] r_status [0:31];
    logic [15:0] r_config [0:15];

    assign w_accept  = (r_state == S_IDLE) && den;
    assign w_in_bank = (daddr[6:5] == 2'b00) || (daddr[6:4] == 3'b100);

    // Read mux over both banks; sees register contents before any same-edge update.
    always_comb begin
        w_rd_data = 16'h0000;
        if (daddr[6:5] == 2'b00) begin
            w_rd_data = r_status[daddr[4:0]];
        end else if (daddr[6:4] == 3'b100) begin
            w_rd_data = r_config[daddr[3:0]];
        end else begin
            w_rd_data = 16'h0000;
        end
    end

    // Snapshot seen by the response; writes always answer with zero data.
    always_comb begin
        w_snap_next = r_snap;
        if (w_accept) begin
            w_snap_next = dwe ? 16'h0000 : w_rd_data;
        end else begin
            w_snap_next = r_snap;
        end
    end

    // Next-state logic: BUSY leaves one cycle early so drdy lands exactly RD_LATENCY after den.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        case (r_state)
            S_IDLE: begin
                if (den) begin
                    if (RD_LATENCY == 1) begin
                        w_next_state = S_RESP;
                        w_next_count = 4'd0;
                    end else begin
                        w_next_state = S_BUSY;
                        w_next_count = LAT_M1;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_BUSY: begin
                w_next_count = r_count - 4'd1;
                if (r_count == 4'd1) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_BUSY;
                end
            end
            S_RESP: begin
                w_next_state = S_IDLE;
                w_next_count = 4'd0;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_count = 4'd0;
            end
        endcase
    end

    // FSM state, request capture and registered DRP outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_count <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 7'h00;
            r_wdata <= 16'h0000;
            r_snap  <= 16'h0000;
            r_dout  <= 16'h0000;
            r_drdy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
            r_snap  <= w_snap_next;
            if (w_accept) begin
                r_we    <= dwe;
                r_addr  <= daddr;
                r_wdata <= di;
            end
            r_drdy <= (w_next_state == S_RESP);
            r_dout <= (w_next_state == S_RESP) ? w_snap_next : 16'h0000;
        end
    end

    // Register banks: status from the fabric port, config committed in the RESP cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                r_status[i] <= 16'h0000;
            end
            for (int j = 0; j < 16; j++) begin
                r_config[j] <= 16'h0000;
            end
        end else begin
            if (meas_we) begin
                r_status[meas_addr] <= meas_data;
            end
            if ((r_state == S_RESP) && r_we && (r_addr[6:4] == 3'b100)) begin
                r_config[r_addr[3:0]] <= r_wdata;
            end
        end
    end

    assign w_eoc_next = (r_eoc_cnt == EOC_LAST) ? 16'd0 : (r_eoc_cnt + 16'd1);

    // Free-running conversion counter, independent of DRP traffic.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_eoc_cnt <= 16'd0;
            r_eoc     <= 1'b0;
        end else begin
            r_eoc_cnt <= w_eoc_next;
            r_eoc     <= (w_eoc_next == EOC_LAST);
        end
    end

    assign dout = r_dout;
    assign drdy = r_drdy;
    assign eoc  = r_eoc;

`ifdef DRP_PROTO_ERR_EN
    logic r_proto_err;

    // Sticky flag for den while busy or outside both banks.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_proto_err <= 1'b0;
        end else if (den && ((r_state != S_IDLE) || !w_in_bank)) begin
            r_proto_err <= 1'b1;
        end
    end

    assign proto_err = r_proto_err;
`else
    logic w_unused;
    assign w_unused  = w_in_bank;
    assign proto_err = 1'b0;
`endif

endmodule
